// File: rtl/clint_trap_seq.sv
// Purpose : trap/mret sequencer on the core's CSR clint write port. It detects
//           ecall/ebreak/mret from ex and enabled machine interrupts, holds the
//           pipeline, writes mepc/mcause/mstatus and issues a one-cycle redirect.
// Latency : trap accept to redirect is 4 cycles; mret accept to redirect is 2 cycles.
// Backpressure: hold_flag_o stalls the pipeline from the accept cycle until the
//           redirect. Events arriving while busy are ignored, and irq_i stays pending as a level.
//
// Ports:
//   clk, rst_n          core clock and asynchronous active-low reset
//   ecall_i/ebreak_i    ex holds a valid ecall / ebreak
//   mret_i              ex holds a valid mret
//   irq_i               level machine interrupt request
//   inst_addr_i         PC of the instruction in ex
//   global_int_en_i     mstatus.MIE
//   csr_mtvec_i/csr_mepc_i/csr_mstatus_i   current CSR values
//   csr_we_o/csr_waddr_o/csr_data_o        clint CSR write port
//   hold_flag_o         pipeline hold request
//   int_assert_o        one-cycle redirect strobe
//   int_addr_o          redirect target, valid when int_assert_o is 1
module clint_trap_seq #(
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] CAUSE_ECALL  = 32'h0000_000B,
  parameter logic [DATA_W-1:0] CAUSE_EBREAK = 32'h0000_0003,
  parameter logic [DATA_W-1:0] CAUSE_IRQ    = 32'h8000_0007
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ecall_i,
  input  logic              ebreak_i,
  input  logic              mret_i,
  input  logic              irq_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              global_int_en_i,
  input  logic [DATA_W-1:0] csr_mtvec_i,
  input  logic [DATA_W-1:0] csr_mepc_i,
  input  logic [DATA_W-1:0] csr_mstatus_i,
  output logic              csr_we_o,
  output logic [ADDR_W-1:0] csr_waddr_o,
  output logic [DATA_W-1:0] csr_data_o,
  output logic              hold_flag_o,
  output logic              int_assert_o,
  output logic [ADDR_W-1:0] int_addr_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTATUS,
    S_T_JUMP,
    S_R_MSTATUS,
    S_R_JUMP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] cause_q, cause_d;

  // mstatus images. The current value is used in the write cycle itself, so an
  // ex CSR write made in the accept cycle is already visible here.
  logic [DATA_W-1:0] mstatus_trap, mstatus_mret;

  always_comb begin
    // Trap entry: MPIE <= MIE, MIE <= 0.
    mstatus_trap    = csr_mstatus_i;
    mstatus_trap[7] = csr_mstatus_i[3];
    mstatus_trap[3] = 1'b0;
    // Return: MIE <= MPIE, MPIE <= 1.
    mstatus_mret    = csr_mstatus_i;
    mstatus_mret[3] = csr_mstatus_i[7];
    mstatus_mret[7] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cause_d      = cause_q;
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_data_o   = '0;
    hold_flag_o  = 1'b0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;

    case (state_q)
      S_IDLE: begin
        // Fixed priority. The interrupt is accepted like an ex event, so the
        // instruction in ex is squashed and resumes at mepc.
        if (ecall_i) begin
          hold_flag_o = 1'b1;
          pc_d        = inst_addr_i;
          cause_d     = CAUSE_ECALL;
          state_d     = S_W_MEPC;
        end else if (ebreak_i) begin
          hold_flag_o = 1'b1;
          pc_d        = inst_addr_i;
          cause_d     = CAUSE_EBREAK;
          state_d     = S_W_MEPC;
        end else if (mret_i) begin
          hold_flag_o = 1'b1;
          state_d     = S_R_MSTATUS;
        end else if (irq_i && global_int_en_i) begin
          hold_flag_o = 1'b1;
          pc_d        = inst_addr_i;
          cause_d     = CAUSE_IRQ;
          state_d     = S_W_MEPC;
        end
      end
      S_W_MEPC: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_W'(CSR_MEPC);
        csr_data_o  = DATA_W'(pc_q);
        state_d     = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_W'(CSR_MCAUSE);
        csr_data_o  = cause_q;
        state_d     = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_W'(CSR_MSTATUS);
        csr_data_o  = mstatus_trap;
        state_d     = S_T_JUMP;
      end
      S_T_JUMP: begin
        // The FSM is not IDLE here, so a pending irq cannot be accepted in the
        // redirect cycle.
        hold_flag_o  = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = ADDR_W'(csr_mtvec_i);
        state_d      = S_IDLE;
      end
      S_R_MSTATUS: begin
        hold_flag_o = 1'b1;
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_W'(CSR_MSTATUS);
        csr_data_o  = mstatus_mret;
        state_d     = S_R_JUMP;
      end
      S_R_JUMP: begin
        hold_flag_o  = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = ADDR_W'(csr_mepc_i);
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_clint_trap_seq.sv
// Purpose : self-checking bench for clint_trap_seq. It runs directed scenarios and
//           then randomized transactions against a transaction-level expected trace.
// Latency : each transaction spans one accept cycle plus 4 (trap) or 2 (mret) cycles.
// Backpressure: none. Inputs are driven at negedge and outputs are sampled 2 ns later.
module tb_clint_trap_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ecall_i = 1'b0, ebreak_i = 1'b0, mret_i = 1'b0, irq_i = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic        global_int_en_i = 1'b0;
  logic [31:0] csr_mtvec_i = '0, csr_mepc_i = '0, csr_mstatus_i = '0;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o, csr_data_o;
  logic        hold_flag_o, int_assert_o;
  logic [31:0] int_addr_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clint_trap_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ecall_i         (ecall_i),
    .ebreak_i        (ebreak_i),
    .mret_i          (mret_i),
    .irq_i           (irq_i),
    .inst_addr_i     (inst_addr_i),
    .global_int_en_i (global_int_en_i),
    .csr_mtvec_i     (csr_mtvec_i),
    .csr_mepc_i      (csr_mepc_i),
    .csr_mstatus_i   (csr_mstatus_i),
    .csr_we_o        (csr_we_o),
    .csr_waddr_o     (csr_waddr_o),
    .csr_data_o      (csr_data_o),
    .hold_flag_o     (hold_flag_o),
    .int_assert_o    (int_assert_o),
    .int_addr_o      (int_addr_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Expected-behaviour model: event priority, causes and mstatus rewrites.
  function automatic int kind_of(bit ec, bit eb, bit mr, bit irq, bit gie);
    if (ec) return 1;
    if (eb) return 2;
    if (mr) return 3;
    if (irq && gie) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] cause_of(int k);
    case (k)
      1: return 32'h0000_000B;
      2: return 32'h0000_0003;
      default: return 32'h8000_0007;
    endcase
  endfunction

  function automatic logic [31:0] mst_trap(logic [31:0] m);
    logic [31:0] r;
    r = m & ~32'h88;
    if (m[3]) r = r | 32'h80;
    return r;
  endfunction

  function automatic logic [31:0] mst_mret(logic [31:0] m);
    logic [31:0] r;
    r = (m & ~32'h8) | 32'h80;
    if (m[7]) r = r | 32'h8;
    return r;
  endfunction

  // Inputs must already be driven (just after negedge). This checks one cycle and advances.
  task automatic expect_cycle(input string tag, input bit we, input logic [31:0] wa,
                              input logic [31:0] wd, input bit hold, input bit ast,
                              input logic [31:0] ia);
    #2;
    chk({tag, ".we"},    32'(csr_we_o),     32'(we));
    chk({tag, ".waddr"}, csr_waddr_o,       wa);
    chk({tag, ".wdata"}, csr_data_o,        wd);
    chk({tag, ".hold"},  32'(hold_flag_o),  32'(hold));
    chk({tag, ".ast"},   32'(int_assert_o), 32'(ast));
    chk({tag, ".iaddr"}, int_addr_o,        ia);
    @(negedge clk);
  endtask

  task automatic idle_cycle(input string tag);
    expect_cycle(tag, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // While the sequencer is busy, events are randomized to show they are ignored.
  task automatic drive_busy(input bit noise);
    if (noise) begin
      ecall_i         = ($urandom_range(0, 1) == 1);
      ebreak_i        = ($urandom_range(0, 1) == 1);
      mret_i          = ($urandom_range(0, 1) == 1);
      irq_i           = ($urandom_range(0, 1) == 1);
      global_int_en_i = ($urandom_range(0, 1) == 1);
      inst_addr_i     = $urandom;
    end else begin
      ecall_i  = 1'b0;
      ebreak_i = 1'b0;
      mret_i   = 1'b0;
    end
  endtask

  task automatic run_txn(input string tag, input bit ec, input bit eb, input bit mr,
                         input bit irq, input bit gie, input logic [31:0] pc,
                         input logic [31:0] mtvec, input logic [31:0] mepc,
                         input logic [31:0] m0, input logic [31:0] m1, input bit noise);
    int k;
    k = kind_of(ec, eb, mr, irq, gie);
    ecall_i = ec; ebreak_i = eb; mret_i = mr; irq_i = irq; global_int_en_i = gie;
    inst_addr_i = pc; csr_mtvec_i = mtvec; csr_mepc_i = mepc; csr_mstatus_i = m0;
    expect_cycle({tag, ".acc"}, 1'b0, 32'h0, 32'h0, (k != 0), 1'b0, 32'h0);
    if (k == 0) return;
    csr_mstatus_i = m1;
    if (k == 3) begin
      drive_busy(noise);
      expect_cycle({tag, ".rmst"}, 1'b1, 32'h300, mst_mret(m1), 1'b1, 1'b0, 32'h0);
      drive_busy(noise);
      expect_cycle({tag, ".rjmp"}, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, mepc);
    end else begin
      drive_busy(noise);
      expect_cycle({tag, ".mepc"}, 1'b1, 32'h341, pc, 1'b1, 1'b0, 32'h0);
      drive_busy(noise);
      expect_cycle({tag, ".mcause"}, 1'b1, 32'h342, cause_of(k), 1'b1, 1'b0, 32'h0);
      drive_busy(noise);
      expect_cycle({tag, ".mst"}, 1'b1, 32'h300, mst_trap(m1), 1'b1, 1'b0, 32'h0);
      drive_busy(noise);
      expect_cycle({tag, ".tjmp"}, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, mtvec);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #3;
    chk("rst.we",   32'(csr_we_o),     32'h0);
    chk("rst.hold", 32'(hold_flag_o),  32'h0);
    chk("rst.ast",  32'(int_assert_o), 32'h0);
    chk("rst.addr", int_addr_o,        32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle_cycle("idle0");

    // ecall, 4-cycle trap sequence, MIE moves into MPIE.
    run_txn("ecall", 1, 0, 0, 0, 0, 32'h100, 32'h80, 32'h0, 32'h8, 32'h8, 0);
    // Interrupt is masked while MIE=0.
    run_txn("irq_off", 0, 0, 0, 1, 0, 32'h200, 32'h80, 32'h0, 32'h0, 32'h0, 0);
    run_txn("irq_on", 0, 0, 0, 1, 1, 32'h204, 32'h80, 32'h0, 32'h8, 32'h8, 0);
    // ecall wins over irq. Afterwards MIE=0 keeps the irq pending.
    run_txn("ec_irq", 1, 0, 0, 1, 1, 32'h300, 32'hC0, 32'h0, 32'h8, 32'h8, 0);
    run_txn("irq_pend", 0, 0, 0, 1, 0, 32'h304, 32'hC0, 32'h0, 32'h80, 32'h80, 0);
    irq_i = 1'b0;
    // mret restores MIE from MPIE.
    run_txn("mret", 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h104, 32'h80, 32'h80, 0);
    // mstatus is sampled in the write cycle, not at accept.
    run_txn("mst_late", 0, 1, 0, 0, 0, 32'h400, 32'h90, 32'h0, 32'h0, 32'h1808, 0);
    // Back-to-back ebreak and mret.
    run_txn("b2b_eb", 0, 1, 0, 0, 0, 32'h500, 32'hA0, 32'h0, 32'h8, 32'h8, 0);
    run_txn("b2b_mr", 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h504, 32'h80, 32'h80, 0);

    // Reset during W_MCAUSE aborts with no later writes or redirect.
    ecall_i = 1'b1; inst_addr_i = 32'h600; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h80;
    expect_cycle("ra.acc", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    ecall_i = 1'b0;
    expect_cycle("ra.mepc", 1'b1, 32'h341, 32'h600, 1'b1, 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    #1 chk("ra.we_async",   32'(csr_we_o),    32'h0);
    chk("ra.hold_async",    32'(hold_flag_o), 32'h0);
    chk("ra.data_async",    csr_data_o,       32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle_cycle("ra.post");

    // Randomized transactions with noise while busy.
    for (int t = 0; t < 150; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0;
        irq_i = ($urandom_range(0, 1) == 1); global_int_en_i = 1'b0;
        inst_addr_i = $urandom;
        idle_cycle("rnd.gap");
      end
      run_txn("rnd",
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 1) == 1),
              $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
              $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
